mixed_precision_sequencer: RTL and testbench

// - Parametrised successor of the ID-stage mixed-precision cycle controller; sits beside the decoder.
// - Owns the sub-word cycle counters used by mixed-precision dotp/sdotp and MAC-load ops; no longer relies on an external CSR.
// - Supports NUM_CTX independent contexts, each with its own cycle counter and skip counter.
// - Generalises the operand ratio to 2^MAX_RATIO_LOG2, adds a CSR preload/clear path and a wrap pulse.

---
 rtl/mixed_precision_sequencer_pkg.sv | 45 ++++
 rtl/mixed_precision_sequencer_if.sv | 41 ++++
 rtl/mixed_precision_sequencer_ctx_counter.sv | 66 ++++++
 rtl/mixed_precision_sequencer.sv | 92 +++++++++
 tb/tb_mixed_precision_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/mixed_precision_sequencer_pkg.sv
// Shared types and constants for the mixed-precision sequencer: opcodes, sub-word formats,
// the source select encoding and the format-to-ratio helper.
package mixed_precision_sequencer_pkg;

    localparam logic [6:0]  OPCODE_VECOP    = 7'h57;
    localparam logic [6:0]  OPCODE_MAC_LOAD = 7'h0b;
    localparam logic [6:0]  OPCODE_SYSTEM   = 7'h73;

    localparam logic [5:0]  VEC_OP_DOTUP    = 6'b100000;
    localparam logic [5:0]  VEC_OP_DOTUSP   = 6'b100010;
    localparam logic [5:0]  VEC_OP_DOTSP    = 6'b100110;
    localparam logic [5:0]  VEC_OP_SDOTUP   = 6'b101000;
    localparam logic [5:0]  VEC_OP_SDOTUSP  = 6'b101010;
    localparam logic [5:0]  VEC_OP_SDOTSP   = 6'b101110;

    localparam logic [11:0] CSR_MIXED_CYCLE = 12'h00D;

    typedef enum logic [2:0] {
        IVEC_NONE  = 3'd0,
        MIXED_2x4  = 3'd1,
        MIXED_4x8  = 3'd2,
        MIXED_8x16 = 3'd3,
        MIXED_2x8  = 3'd4,
        MIXED_4x16 = 3'd5,
        MIXED_2x16 = 3'd6,
        IVEC_OTHER = 3'd7
    } ivec_mode_fmt_e;

    typedef enum logic [1:0] {
        MPC_CSR       = 2'd0,
        MPC_CSR_WRITE = 2'd1,
        MPC_MIX_CNTRL = 2'd2
    } mux_sel_mpc_e;

    // log2 of the operand width ratio; the cycle count per op is 2^result
    function automatic logic [1:0] fmt_log2(input ivec_mode_fmt_e fmt);
        case (fmt)
            MIXED_2x4, MIXED_4x8, MIXED_8x16: fmt_log2 = 2'd1;
            MIXED_2x8, MIXED_4x16:            fmt_log2 = 2'd2;
            MIXED_2x16:                       fmt_log2 = 2'd3;
            default:                          fmt_log2 = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mixed_precision_sequencer_if.sv
// Decoder-side bundle of the mixed-precision sequencer: the decoder drives (master),
// the sequencer consumes and reports its cycle state (slave).
interface mixed_precision_sequencer_if
    import mixed_precision_sequencer_pkg::*;
#(
    parameter int NUM_CTX        = 2,
    parameter int MAX_RATIO_LOG2 = 3,
    parameter int SKIP_W         = 4
);
    localparam int CYC_W = (MAX_RATIO_LOG2 < 1) ? 1 : MAX_RATIO_LOG2;
    localparam int CTX_W = (NUM_CTX < 2) ? 1 : $clog2(NUM_CTX);

    logic                     illegal_insn_i;
    logic                     is_decoding_i;
    logic                     ex_ready_i;
    logic [31:0]              instr_rdata_i;
    ivec_mode_fmt_e           ivec_fmt_i;
    logic [CTX_W-1:0]         ctx_i;
    logic [SKIP_W-1:0]        skip_size_i;
    logic                     csr_we_i;
    logic [CTX_W-1:0]         csr_ctx_i;
    logic [CYC_W-1:0]         csr_wdata_i;
    logic                     clear_i;
    logic [CYC_W-1:0]         cycle_o;
    logic [NUM_CTX*CYC_W-1:0] cycle_all_o;
    logic                     wrap_o;
    mux_sel_mpc_e             mux_sel_mpc_o;

    modport master (
        output illegal_insn_i, is_decoding_i, ex_ready_i, instr_rdata_i, ivec_fmt_i, ctx_i,
               skip_size_i, csr_we_i, csr_ctx_i, csr_wdata_i, clear_i,
        input  cycle_o, cycle_all_o, wrap_o, mux_sel_mpc_o
    );

    modport slave (
        input  illegal_insn_i, is_decoding_i, ex_ready_i, instr_rdata_i, ivec_fmt_i, ctx_i,
               skip_size_i, csr_we_i, csr_ctx_i, csr_wdata_i, clear_i,
        output cycle_o, cycle_all_o, wrap_o, mux_sel_mpc_o
    );

endinterface

// File: rtl/mixed_precision_sequencer_ctx_counter.sv
// One sequencing context: skip counter gating a modulo-R cycle counter, with clear and
// preload overrides (clear > preload > advance).
module mps_ctx_counter #(
    parameter int SKIP_W = 4,
    parameter int CYC_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [CYC_W-1:0]  load_val_i,
    input  logic              adv_i,
    input  logic [SKIP_W-1:0] skip_size_i,
    input  logic [CYC_W-1:0]  rmax_i,
    output logic [CYC_W-1:0]  cycle_o,
    output logic              wrap_o
);

    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [CYC_W-1:0]  cycle_q, cycle_d;
    logic [SKIP_W:0]   skip_inc;
    logic [SKIP_W:0]   skip_lim;

    // One extra bit so an all-ones skip counter still compares correctly
    assign skip_inc = {1'b0, skip_q} + {{SKIP_W{1'b0}}, 1'b1};
    assign skip_lim = (skip_size_i == '0) ? {{SKIP_W{1'b0}}, 1'b1} : {1'b0, skip_size_i};

    always_comb begin
        skip_d  = skip_q;
        cycle_d = cycle_q;
        wrap_o  = 1'b0;
        if (clear_i) begin
            skip_d  = '0;
            cycle_d = '0;
        end else if (load_i) begin
            skip_d  = '0;
            cycle_d = load_val_i;
        end else if (adv_i) begin
            if (skip_inc < skip_lim) begin
                skip_d = skip_inc[SKIP_W-1:0];
            end else begin
                skip_d = '0;
                // >= so a shrunken format or an oversized preload folds back to 0
                if (cycle_q >= rmax_i) begin
                    cycle_d = '0;
                    wrap_o  = (cycle_q != '0) && (rmax_i != '0);
                end else begin
                    cycle_d = cycle_q + {{(CYC_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skip_q  <= '0;
            cycle_q <= '0;
        end else begin
            skip_q  <= skip_d;
            cycle_q <= cycle_d;
        end
    end

    assign cycle_o = cycle_q;

endmodule

// File: rtl/mixed_precision_sequencer.sv
// Mixed-precision cycle sequencer beside the ID-stage decoder: decodes mixed ops, steers
// fire/preload to per-context counters and registers the MPC source select.
module mixed_precision_sequencer
    import mixed_precision_sequencer_pkg::*;
#(
    parameter int NUM_CTX        = 2,
    parameter int MAX_RATIO_LOG2 = 3,
    parameter int SKIP_W         = 4
) (
    input logic                      clk,
    input logic                      rst_n,
    mixed_precision_sequencer_if.slave bus
);

    localparam int CYC_W = (MAX_RATIO_LOG2 < 1) ? 1 : MAX_RATIO_LOG2;
    localparam int CTX_W = (NUM_CTX < 2) ? 1 : $clog2(NUM_CTX);

    logic [6:0]  opcode;
    logic [5:0]  funct6;
    logic        is_vec_mix, is_mac_load, is_mix_op, is_csr_write, fire;
    logic [CYC_W-1:0] rmax;
    int unsigned      ratio_lg;
    logic [NUM_CTX-1:0][CYC_W-1:0] cyc_arr;
    logic [NUM_CTX-1:0]            wrap_arr;
    logic [CYC_W-1:0]              cycle_sel;
    mux_sel_mpc_e mux_sel_q, mux_sel_d;
    logic         unused_instr;

    assign opcode       = bus.instr_rdata_i[6:0];
    assign funct6       = bus.instr_rdata_i[31:26];
    assign unused_instr = ^bus.instr_rdata_i[19:14];

    assign is_vec_mix  = (opcode == OPCODE_VECOP) &&
                         (funct6 inside {VEC_OP_DOTUP, VEC_OP_DOTUSP, VEC_OP_DOTSP,
                                         VEC_OP_SDOTUP, VEC_OP_SDOTUSP, VEC_OP_SDOTSP});
    assign is_mac_load = (opcode == OPCODE_MAC_LOAD) && (bus.instr_rdata_i[11:7] != 5'd0);
    assign is_mix_op   = is_vec_mix || is_mac_load;
    assign is_csr_write = (opcode == OPCODE_SYSTEM) &&
                          (bus.instr_rdata_i[31:20] == CSR_MIXED_CYCLE) &&
                          (bus.instr_rdata_i[13:12] == 2'b01);
    assign fire = !bus.illegal_insn_i && bus.is_decoding_i && bus.ex_ready_i && is_mix_op;

    always_comb begin
        ratio_lg = 32'(fmt_log2(bus.ivec_fmt_i));
        if (ratio_lg > MAX_RATIO_LOG2) ratio_lg = MAX_RATIO_LOG2;
        rmax = CYC_W'((32'd1 << ratio_lg) - 32'd1);
    end

    for (genvar g = 0; g < NUM_CTX; g++) begin : g_ctx
        mps_ctx_counter #(
            .SKIP_W (SKIP_W),
            .CYC_W  (CYC_W)
        ) u_cnt (
            .clk         (clk),
            .rst_n       (rst_n),
            .clear_i     (bus.clear_i),
            .load_i      (bus.csr_we_i && (bus.csr_ctx_i == CTX_W'(g))),
            .load_val_i  (bus.csr_wdata_i),
            .adv_i       (fire && (bus.ctx_i == CTX_W'(g))),
            .skip_size_i (bus.skip_size_i),
            .rmax_i      (rmax),
            .cycle_o     (cyc_arr[g]),
            .wrap_o      (wrap_arr[g])
        );
    end

    always_comb begin
        cycle_sel = '0;
        for (int k = 0; k < NUM_CTX; k++) begin
            if (bus.ctx_i == CTX_W'(k)) cycle_sel = cyc_arr[k];
        end
    end

    // Only the addressed counter can advance, so any wrap belongs to ctx_i
    assign bus.wrap_o      = rst_n && (|wrap_arr);
    assign bus.cycle_o     = rst_n ? cycle_sel : '0;
    assign bus.cycle_all_o = rst_n ? cyc_arr : '0;

    always_comb begin
        mux_sel_d = MPC_CSR;
        if (is_csr_write)   mux_sel_d = MPC_CSR_WRITE;
        else if (is_mix_op) mux_sel_d = MPC_MIX_CNTRL;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) mux_sel_q <= MPC_CSR;
        else        mux_sel_q <= mux_sel_d;
    end

    assign bus.mux_sel_mpc_o = mux_sel_q;

endmodule

// File: tb/tb_mixed_precision_sequencer.sv
// Self-checking bench for mixed_precision_sequencer: directed scenarios plus randomized
// traffic, compared against a per-context arithmetic reference model.
module tb_mixed_precision_sequencer;
    import mixed_precision_sequencer_pkg::*;

    localparam int NUM_CTX = 2;
    localparam int MAXL    = 3;
    localparam int SKIP_W  = 4;
    localparam int CYC_W   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mixed_precision_sequencer_if #(.NUM_CTX(NUM_CTX), .MAX_RATIO_LOG2(MAXL), .SKIP_W(SKIP_W)) bus ();

    mixed_precision_sequencer #(.NUM_CTX(NUM_CTX), .MAX_RATIO_LOG2(MAXL), .SKIP_W(SKIP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int mcyc [NUM_CTX];
    int mskp [NUM_CTX];
    logic [5:0] mix_f6 [6];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int ratio_of(input ivec_mode_fmt_e f);
        case (f)
            MIXED_2x4, MIXED_4x8, MIXED_8x16: return 2;
            MIXED_2x8, MIXED_4x16:            return 4;
            MIXED_2x16:                       return 8;
            default:                          return 1;
        endcase
    endfunction

    // kind: 0 = not a mixed op, 1 = mixed op, 2 = write to the mixed-cycle CSR
    function automatic logic [31:0] mk_instr(input int kind);
        logic [31:0] w;
        w = $urandom;
        case (kind)
            1: begin
                if ($urandom_range(0, 2) != 0) begin
                    w[31:26] = mix_f6[$urandom_range(0, 5)];
                    w[6:0]   = OPCODE_VECOP;
                end else begin
                    w[11:7] = 5'($urandom_range(1, 31));
                    w[6:0]  = OPCODE_MAC_LOAD;
                end
            end
            2: begin
                w[31:20] = CSR_MIXED_CYCLE;
                w[13:12] = 2'b01;
                w[6:0]   = OPCODE_SYSTEM;
            end
            default: begin
                case ($urandom_range(0, 3))
                    0: w[6:0] = 7'h33;
                    1: begin w[31:26] = 6'b000000; w[6:0] = OPCODE_VECOP; end
                    2: begin w[11:7] = 5'd0; w[6:0] = OPCODE_MAC_LOAD; end
                    default: begin
                        w[31:20] = CSR_MIXED_CYCLE; w[13:12] = 2'b10; w[6:0] = OPCODE_SYSTEM;
                    end
                endcase
            end
        endcase
        return w;
    endfunction

    function automatic logic [31:0] all_exp();
        logic [31:0] v = '0;
        for (int k = 0; k < NUM_CTX; k++) v |= 32'(mcyc[k] & 7) << (k * CYC_W);
        return v;
    endfunction

    // One clock: drive inputs, check combinational outputs, clock, check registered state.
    task automatic step(input bit ill, input bit dec, input bit rdy, input int kind,
                        input ivec_mode_fmt_e fmt, input int ctx, input int skip,
                        input bit we, input int wctx, input int wdata, input bit clr);
        int  ncyc [NUM_CTX];
        int  nskp [NUM_CTX];
        int  r, lim;
        bit  fire, exp_wrap;
        mux_sel_mpc_e exp_sel;
        bus.illegal_insn_i = ill;
        bus.is_decoding_i  = dec;
        bus.ex_ready_i     = rdy;
        bus.instr_rdata_i  = mk_instr(kind);
        bus.ivec_fmt_i     = fmt;
        bus.ctx_i          = 1'(ctx);
        bus.skip_size_i    = SKIP_W'(skip);
        bus.csr_we_i       = we;
        bus.csr_ctx_i      = 1'(wctx);
        bus.csr_wdata_i    = CYC_W'(wdata);
        bus.clear_i        = clr;
        #1;
        fire     = !ill && dec && rdy && (kind == 1);
        exp_wrap = 1'b0;
        ncyc = mcyc;
        nskp = mskp;
        r   = ratio_of(fmt);
        lim = (skip == 0) ? 1 : skip;
        if (clr) begin
            foreach (ncyc[k]) begin ncyc[k] = 0; nskp[k] = 0; end
        end else begin
            if (we) begin ncyc[wctx] = wdata; nskp[wctx] = 0; end
            if (fire && !(we && wctx == ctx)) begin
                if (mskp[ctx] + 1 < lim) nskp[ctx] = mskp[ctx] + 1;
                else begin
                    nskp[ctx] = 0;
                    ncyc[ctx] = (mcyc[ctx] >= r - 1) ? 0 : mcyc[ctx] + 1;
                    exp_wrap  = (r > 1) && (mcyc[ctx] != 0) && (ncyc[ctx] == 0);
                end
            end
        end
        check("wrap_o", 32'(bus.wrap_o), 32'(exp_wrap));
        check("cycle_o", 32'(bus.cycle_o), 32'(mcyc[ctx]));
        exp_sel = (kind == 2) ? MPC_CSR_WRITE : (kind == 1) ? MPC_MIX_CNTRL : MPC_CSR;
        @(posedge clk);
        #1;
        mcyc = ncyc;
        mskp = nskp;
        check("cycle_all_o", 32'(bus.cycle_all_o), all_exp());
        check("mux_sel_mpc_o", 32'(bus.mux_sel_mpc_o), 32'(exp_sel));
    endtask

    task automatic fire_n(input int n, input ivec_mode_fmt_e fmt, input int ctx, input int skip);
        for (int i = 0; i < n; i++) step(0, 1, 1, 1, fmt, ctx, skip, 0, 0, 0, 0);
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        bus.illegal_insn_i = 1'b0;
        bus.is_decoding_i  = 1'b1;
        bus.ex_ready_i     = 1'b1;
        bus.instr_rdata_i  = mk_instr(1);
        bus.csr_we_i       = 1'b0;
        bus.clear_i        = 1'b0;
        #1;
        check("rst_wrap_o", 32'(bus.wrap_o), 32'd0);
        check("rst_cycle_o", 32'(bus.cycle_o), 32'd0);
        @(posedge clk);
        #1;
        foreach (mcyc[k]) begin mcyc[k] = 0; mskp[k] = 0; end
        check("rst_cycle_all_o", 32'(bus.cycle_all_o), 32'd0);
        check("rst_mux_sel", 32'(bus.mux_sel_mpc_o), 32'(MPC_CSR));
        rst_n = 1'b1;
    endtask

    initial begin
        mix_f6 = '{VEC_OP_DOTUP, VEC_OP_DOTUSP, VEC_OP_DOTSP,
                   VEC_OP_SDOTUP, VEC_OP_SDOTUSP, VEC_OP_SDOTSP};
        foreach (mcyc[k]) begin mcyc[k] = 0; mskp[k] = 0; end
        bus.ivec_fmt_i  = IVEC_NONE;
        bus.ctx_i       = '0;
        bus.skip_size_i = '0;
        bus.csr_ctx_i   = '0;
        bus.csr_wdata_i = '0;
        @(posedge clk);
        #1;
        reset_now();

        // 2x8, skip 1: 1,2,3,0,1,2 with a single wrap
        fire_n(6, MIXED_2x8, 0, 1);
        check("seq_2x8_end", 32'(bus.cycle_o), 32'd2);

        // 2x16, skip 3 for 24 fires, then skip 0 acting like skip 1
        step(0, 1, 1, 1, MIXED_2x16, 0, 1, 1, 0, 0, 1);
        fire_n(24, MIXED_2x16, 0, 3);
        check("seq_2x16_skip3_end", 32'(bus.cycle_o), 32'd0);
        fire_n(3, MIXED_2x16, 0, 0);
        check("seq_skip0_end", 32'(bus.cycle_o), 32'd3);

        // format shrink mid-sequence: cycle 5 under 2x16, then 4x8 wraps on next advance
        fire_n(2, MIXED_2x16, 0, 1);
        check("shrink_pre", 32'(bus.cycle_o), 32'd5);
        fire_n(1, MIXED_4x8, 0, 1);
        check("shrink_post", 32'(bus.cycle_o), 32'd0);

        // interleaved contexts under 2x4
        for (int i = 0; i < 8; i++) step(0, 1, 1, 1, MIXED_2x4, i % 2, 1, 0, 0, 0, 0);

        // preload collides with fire on the same context, then with fire on the other one
        step(0, 1, 1, 1, MIXED_2x16, 1, 1, 1, 1, 2, 0);
        step(0, 1, 1, 1, MIXED_2x16, 0, 1, 1, 1, 2, 0);

        // stall and illegal leave counters alone
        step(0, 1, 0, 1, MIXED_2x16, 0, 1, 0, 0, 0, 0);
        step(1, 1, 1, 1, MIXED_2x16, 1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, MIXED_2x16, 0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 2, MIXED_2x16, 0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, MIXED_2x16, 0, 1, 0, 0, 0, 0);

        // reset mid-sequence
        fire_n(3, MIXED_2x16, 1, 1);
        reset_now();

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 4) != 0,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : 1,
                 ivec_mode_fmt_e'($urandom_range(0, 7)), $urandom_range(0, 1),
                 $urandom_range(0, 4), $urandom_range(0, 9) == 0, $urandom_range(0, 1),
                 $urandom_range(0, 7), $urandom_range(0, 39) == 0);
            if (i == 200) reset_now();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
